ap_cd_accumulator: RTL
======================

# ap_cd_accumulator

Sequential saturating difference accumulator for the contrastive-divergence weight-update path. Each accepted sample supplies a positive-phase term and a negative-phase term. The block accumulates the saturated difference (pos − neg) over NSAMPLES samples and then presents one result for the weight-update stage.

It is the subtractive, time-multiplexed counterpart of the combinational saturating adder in the forward datapath. It uses the same symmetric clamp range [−Inf, +Inf].

## Interface

Parameters:
- bitlength, 16, word width of all operands and the result (signed two's complement)
- Inf, 16'h7FFF, positive saturation bound; the negative bound is −Inf (16'h8001)
- NSAMPLES, 8, samples accumulated per result (≥1)

Ports:
- clk  input  1  clock
- rst  input  1  reset; synchronous, active-high
- start  input  1  begins an accumulation run; honoured only in IDLE
- in_valid  input  1  pos/neg are valid this cycle
- in_ready  output  1  block accepts a sample this cycle
- pos  input  bitlength  signed positive-phase term
- neg  input  bitlength  signed negative-phase term
- out_valid  output  1  result is valid
- out_ready  input  1  consumer accepts the result
- result  output  bitlength  signed saturated accumulated difference
- sat_flag  output  1  sticky saturation indicator; present only with AP_CD_SAT_FLAG_EN

## Operation

- FSM states are IDLE, ACCUM and OUTPUT. The reset state is IDLE.
- IDLE: in_ready=0, out_valid=0.
  - If start=1, the accumulator clears to 0, the sample counter clears to 0, and the state moves to ACCUM.
- ACCUM: in_ready=1.
  - A sample is taken on the handshake in_valid && in_ready.
  - For each taken sample: d = clamp(pos − neg), then acc = clamp(acc + d).
  - The counter increments on each taken sample.
  - On the NSAMPLES-th take, the state moves to OUTPUT and the final sum is registered into result.
- OUTPUT: in_ready=0, out_valid=1, and result is held stable.
  - On out_valid && out_ready, the state moves to IDLE.
- Arithmetic:
  - All intermediate values are computed at bitlength+2 bits, sign-extended.
  - clamp() maps values > Inf to Inf and values < −Inf to −Inf.
  - An input of 16'h8000 is legal; it is handled by the wide arithmetic and the clamp.
  - The result is never 16'h8000.
- start is ignored in ACCUM and OUTPUT.
- in_valid is ignored outside ACCUM.
- Reset at any point, including mid-ACCUM or in OUTPUT, aborts the run:
  - state=IDLE, acc=0, counter=0
  - result=0, out_valid=0, in_ready=0
  - sat_flag=0
  - No partial result is emitted.

## Timing

- All outputs are registered.
- Reset values: in_ready=0, out_valid=0, result=0, sat_flag=0.
- start in cycle t gives in_ready=1 in cycle t+1.
- Back-to-back samples are accepted, one per cycle, with no bubbles.
- The NSAMPLES-th take in cycle t gives out_valid=1 in cycle t+1, with result valid in that same cycle. in_ready=0 from cycle t+1.
- Minimum run length is 1 + NSAMPLES + 1 cycles (start, takes, output handshake).
- A result handshake in cycle t returns the block to IDLE in cycle t+1.
  - A new start is honoured in cycle t+1.
  - A start asserted in the handshake cycle t itself is ignored.
- Backpressure: while out_ready=0, out_valid and result hold indefinitely.
- NSAMPLES=1: the first take moves the state directly to OUTPUT.

## Configuration

- AP_CD_SAT_FLAG_EN defined:
  - The sat_flag port exists.
  - sat_flag sets when either clamp fires on a taken sample. It is visible from the cycle after that sample.
  - It stays set through OUTPUT.
  - It clears on start or rst.
- AP_CD_SAT_FLAG_EN undefined:
  - The port and its logic are absent.
  - The accumulation behaviour is otherwise identical.

## Structure

- Shared package ap_pkg holds:
  - the state enum (IDLE/ACCUM/OUTPUT)
  - the default bitlength and Inf constants
  - the widened-width localparam helper
- Sub-module ap_sat_clamp is combinational: it clamps a bitlength+2 value to [−Inf, Inf] and reports whether it clamped. It is instantiated twice, once for the difference and once for the sum.
- The counter width is $clog2(NSAMPLES+1).

## Test plan

- Nominal run, NSAMPLES=4, pos={100,200,300,400}, neg={10,20,30,40}, out_ready=1 → result=900 (0x0384); out_valid for 1 cycle; sat_flag=0.
- Positive saturation: pos=0x7000, neg=0x9000 for 4 samples → each difference clamps to 0x7FFF; result=0x7FFF; sat_flag=1.
- Negative saturation including 0x8000: pos=0x8000, neg=0x7FFF, 1 sample, NSAMPLES=1 → result=0x8001; sat_flag=1.
- Backpressure and gaps: in_valid toggled 1,0,1,0,…; out_ready held 0 for 5 cycles after out_valid →
  - exactly 4 takes
  - result stable for 5 cycles
  - in_ready=0 throughout OUTPUT
  - a start pulsed during OUTPUT is ignored
- Reset mid-run: rst asserted after 2 takes → next cycle in_ready=0, out_valid=0, result=0. A subsequent start plus 4 samples of pos=1, neg=0 → result=4.
- Back-to-back runs: start asserted in the cycle after the result handshake → second run's result is independent of the first (accumulator cleared).

Source files
------------

// File: rtl/ap_pkg.sv
// ap_pkg
// Shared definitions for the accumulate/propagate datapath blocks:
//   - state_e     : run-control FSM states (IDLE / ACCUM / OUTPUT)
//   - AP_BITLENGTH: default operand/result word width
//   - AP_INF      : default symmetric saturation bound (+Inf; the low bound is -Inf)
//   - ap_wide_w() : width of intermediates, two guard bits above the word width
package ap_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCUM  = 2'd1,
        ST_OUTPUT = 2'd2
    } state_e;

    localparam int          AP_BITLENGTH = 16;
    localparam logic [15:0] AP_INF       = 16'h7FFF;

    // Two guard bits hold the sum or difference of two full-range words,
    // including the -2^(w-1) encoding, without wrapping.
    function automatic int ap_wide_w(input int w);
        return w + 2;
    endfunction

endpackage

// File: rtl/ap_sat_clamp.sv
// ap_sat_clamp
// Combinational symmetric clamp of a widened signed value to [-Inf, +Inf].
// Ports:
//   x_i       in  bitlength+2  signed widened value
//   y_o       out bitlength    signed clamped value (never the most negative code)
//   clamped_o out 1            high when x_i lay outside [-Inf, +Inf]
module ap_sat_clamp #(
    parameter int                   bitlength = 16,
    parameter logic [bitlength-1:0] Inf       = 16'h7FFF
) (
    input  logic signed [bitlength+1:0] x_i,
    output logic signed [bitlength-1:0] y_o,
    output logic                        clamped_o
);

    localparam logic signed [bitlength+1:0] POS_LIM = {2'b00, Inf};
    localparam logic signed [bitlength+1:0] NEG_LIM = -POS_LIM;

    always_comb begin
        y_o       = x_i[bitlength-1:0];
        clamped_o = 1'b0;
        if (x_i > POS_LIM) begin
            y_o       = POS_LIM[bitlength-1:0];
            clamped_o = 1'b1;
        end else if (x_i < NEG_LIM) begin
            y_o       = NEG_LIM[bitlength-1:0];
            clamped_o = 1'b1;
        end
    end

endmodule

// File: rtl/ap_cd_accumulator.sv
// ap_cd_accumulator
// Sequential saturating difference accumulator for the contrastive-divergence
// weight-update path. Each taken sample adds clamp(pos - neg) into a clamped
// running sum; after NSAMPLES takes the sum is presented on result.
// Optional feature macro: AP_CD_SAT_FLAG_EN (adds the sticky sat_flag output).
// Ports:
//   clk        in   1          clock
//   rst        in   1          synchronous active-high reset, aborts any run
//   start      in   1          begins a run (honoured only in IDLE)
//   in_valid   in   1          pos/neg valid
//   in_ready   out  1          sample accepted this cycle (ACCUM)
//   pos, neg   in   bitlength  signed positive/negative phase terms
//   out_valid  out  1          result valid (OUTPUT)
//   out_ready  in   1          consumer accepts the result
//   result     out  bitlength  signed saturated accumulated difference
//   sat_flag   out  1          sticky clamp indicator (AP_CD_SAT_FLAG_EN only)
module ap_cd_accumulator
    import ap_pkg::*;
#(
    parameter int                   bitlength = AP_BITLENGTH,
    parameter logic [bitlength-1:0] Inf       = AP_INF,
    parameter int                   NSAMPLES  = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic signed [bitlength-1:0] pos,
    input  logic signed [bitlength-1:0] neg,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic signed [bitlength-1:0] result
`ifdef AP_CD_SAT_FLAG_EN
    ,
    output logic                        sat_flag
`endif
);

    localparam int WW    = ap_wide_w(bitlength);
    localparam int CNT_W = $clog2(NSAMPLES + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NSAMPLES - 1);

    state_e state_q, state_d;

    logic                        in_ready_q, in_ready_d;
    logic                        out_valid_q, out_valid_d;
    logic signed [bitlength-1:0] acc_q;
    logic signed [bitlength-1:0] result_q;
    logic [CNT_W-1:0]            cnt_q;

    logic take;
    logic last_take;

    logic signed [WW-1:0]        diff_w;
    logic signed [WW-1:0]        sum_w;
    logic signed [bitlength-1:0] diff_c;
    logic signed [bitlength-1:0] sum_c;
    logic                        diff_clamped;
    logic                        sum_clamped;

    // in_ready_q is high exactly while in ACCUM, so it doubles as the state qualifier.
    assign take      = in_valid && in_ready_q;
    assign last_take = take && (cnt_q == LAST_CNT);

    // Wide arithmetic: sign-extend both operands so 16'h8000 inputs cannot wrap.
    assign diff_w = {{2{pos[bitlength-1]}}, pos} - {{2{neg[bitlength-1]}}, neg};
    assign sum_w  = {{2{acc_q[bitlength-1]}}, acc_q} + {{2{diff_c[bitlength-1]}}, diff_c};

    ap_sat_clamp #(.bitlength(bitlength), .Inf(Inf)) u_clamp_diff (
        .x_i       (diff_w),
        .y_o       (diff_c),
        .clamped_o (diff_clamped)
    );

    ap_sat_clamp #(.bitlength(bitlength), .Inf(Inf)) u_clamp_sum (
        .x_i       (sum_w),
        .y_o       (sum_c),
        .clamped_o (sum_clamped)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:   if (start)                  state_d = ST_ACCUM;
            ST_ACCUM:  if (last_take)              state_d = ST_OUTPUT;
            ST_OUTPUT: if (out_valid_q && out_ready) state_d = ST_IDLE;
            default:                               state_d = ST_IDLE;
        endcase
    end

    // Output logic: decoded from the next state so the registered flags
    // line up with the state they describe.
    always_comb begin
        in_ready_d  = (state_d == ST_ACCUM);
        out_valid_d = (state_d == ST_OUTPUT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    // Accumulator, sample counter and result register
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
        end else if (state_q == ST_IDLE && start) begin
            acc_q <= '0;
            cnt_q <= '0;
        end else if (take) begin
            acc_q <= sum_c;
            cnt_q <= cnt_q + 1'b1;
            if (last_take) begin
                result_q <= sum_c;
            end
        end
    end

`ifdef AP_CD_SAT_FLAG_EN
    logic sat_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sat_q <= 1'b0;
        end else if (state_q == ST_IDLE && start) begin
            sat_q <= 1'b0;
        end else if (take && (diff_clamped || sum_clamped)) begin
            sat_q <= 1'b1;
        end
    end

    assign sat_flag = sat_q;
`else
    logic sat_unused;
    assign sat_unused = diff_clamped | sum_clamped;
`endif

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign result    = result_q;

endmodule
